// File: rtl/nvdla_glb_csb_arb.sv
// Round-robin arbiter sharing the GLB CSB slave port between NREQ masters, one transaction in flight.
// Grant is combinational in IDLE; responses reach the owner one cycle after GLB, or a synthesised error after TIMEOUT.
module nvdla_glb_csb_arb #(
  parameter int NREQ    = 2,
  parameter int PD_W    = 63,
  parameter int RSP_W   = 34,
  parameter int TIMEOUT = 255
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic [NREQ-1:0]       mst_req_pvld,
  output logic [NREQ-1:0]       mst_req_prdy,
  input  logic [NREQ*PD_W-1:0]  mst_req_pd,
  output logic                  csb2glb_req_pvld,
  input  logic                  csb2glb_req_prdy,
  output logic [PD_W-1:0]       csb2glb_req_pd,
  input  logic                  glb2csb_resp_valid,
  input  logic [RSP_W-1:0]      glb2csb_resp_pd,
  output logic [NREQ-1:0]       mst_resp_valid,
  output logic [RSP_W-1:0]      mst_resp_pd,
  output logic                  timeout_err,
  output logic                  unexp_resp
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic [PTR_W-1:0] rr_ptr_q,   rr_ptr_d;
  logic [PTR_W-1:0] owner_q,    owner_d;
  logic             exp_rsp_q,  exp_rsp_d;
  logic             exp_wr_q,   exp_wr_d;
  logic [PD_W-1:0]  req_pd_q,   req_pd_d;
  logic [WD_W-1:0]  wd_cnt_q,   wd_cnt_d;
  logic [NREQ-1:0]  resp_vld_q, resp_vld_d;
  logic [RSP_W-1:0] resp_pd_q,  resp_pd_d;
  logic             tmo_q,      tmo_d;
  logic             unexp_q,    unexp_d;

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PD_W-1:0]  win_pd;

  // Search upward from rr_ptr, wrapping at NREQ; the first requester found wins.
  always_comb begin
    logic [PTR_W:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NREQ)) begin
        cand = cand - (PTR_W+1)'(NREQ);
      end
      if (!win_found && mst_req_pvld[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    win_pd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_pd = mst_req_pd[i*PD_W +: PD_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    exp_rsp_d    = exp_rsp_q;
    exp_wr_d     = exp_wr_q;
    req_pd_d     = req_pd_q;
    wd_cnt_d     = wd_cnt_q;
    resp_vld_d   = '0;
    resp_pd_d    = resp_pd_q;
    tmo_d        = 1'b0;
    unexp_d      = 1'b0;
    mst_req_prdy = '0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          mst_req_prdy[win_idx] = 1'b1;
          req_pd_d  = win_pd;
          owner_d   = win_idx;
          exp_wr_d  = win_pd[54];
          // Reads and non-posted writes expect a response; posted writes do not.
          exp_rsp_d = ~win_pd[54] | win_pd[55];
          rr_ptr_d  = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (csb2glb_req_prdy) begin
          wd_cnt_d = '0;
          state_d  = exp_rsp_q ? ST_WAIT : ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wd_cnt_q != WD_MAX) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
        // A real response wins over a watchdog expiring in the same cycle.
        if (glb2csb_resp_valid) begin
          resp_vld_d[owner_q] = 1'b1;
          resp_pd_d           = glb2csb_resp_pd;
          state_d             = ST_IDLE;
        end else if (wd_cnt_q == WD_LAST) begin
          resp_vld_d[owner_q]  = 1'b1;
          resp_pd_d            = '0;
          resp_pd_d[RSP_W-1]   = exp_wr_q;
          resp_pd_d[RSP_W-2]   = 1'b1;
          tmo_d                = 1'b1;
          state_d              = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (glb2csb_resp_valid && (state_q != ST_WAIT)) begin
      unexp_d = 1'b1;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      exp_rsp_q  <= 1'b0;
      exp_wr_q   <= 1'b0;
      req_pd_q   <= '0;
      wd_cnt_q   <= '0;
      resp_vld_q <= '0;
      resp_pd_q  <= '0;
      tmo_q      <= 1'b0;
      unexp_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      exp_rsp_q  <= exp_rsp_d;
      exp_wr_q   <= exp_wr_d;
      req_pd_q   <= req_pd_d;
      wd_cnt_q   <= wd_cnt_d;
      resp_vld_q <= resp_vld_d;
      resp_pd_q  <= resp_pd_d;
      tmo_q      <= tmo_d;
      unexp_q    <= unexp_d;
    end
  end

  assign csb2glb_req_pvld = (state_q == ST_ISSUE);
  assign csb2glb_req_pd   = req_pd_q;
  assign mst_resp_valid   = resp_vld_q;
  assign mst_resp_pd      = resp_pd_q;
  assign timeout_err      = tmo_q;
  assign unexp_resp       = unexp_q;

endmodule
